multiciclo_sequencer: RTL and testbench

Control state machine for the RV32I multicycle datapath. Decodes the opcode held in the instruction register and steps the datapath through fetch, decode, execute, memory and write-back. Drives every datapath enable and mux select. Stretches memory states on a ready handshake, with a timeout fault.

---
 rtl/multiciclo_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_multiciclo_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiciclo_sequencer.sv
// Control FSM for the RV32I multicycle datapath: fetch, decode, execute, memory, write-back.
// Define INSTR_COUNT_EN to add the 32-bit retired-instruction counter output instret.
module multiciclo_sequencer #(
  parameter int WAIT_LIMIT = 16,
  parameter int STATE_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               MemoryAddressOrigin,
  output logic               ReadMemory,
  output logic               WriteMemory,
  output logic               WriteInstructionRegister,
  output logic               WriteCurrentPC,
  output logic               WritePC,
  output logic               Branch,
  output logic               PCOrigin,
  output logic [1:0]         RegisterInputOrigin,
  output logic               WriteRegister,
  output logic [1:0]         ALUInputAOrigin,
  output logic [1:0]         ALUInputBOrigin,
  output logic [1:0]         ALUOp,
  output logic               halted,
  output logic [1:0]         fault,
  output logic [STATE_W-1:0] state_dbg
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]        instret
`endif
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, LUI, WB_ALU, MEM_ADDR, MEM_READ,
    WB_MEM, MEM_WRITE, BRANCH, JAL, JALR, HALT, TRAP
  } stateT;

  localparam int CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;

  stateT            state;
  stateT            nextState;
  logic [CNT_W-1:0] waitCount;
  logic             waitState;
  logic             timeout;
  logic             setIllegal;
  logic             setTimeout;

  assign state_dbg = state;
  assign waitState = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign timeout   = (WAIT_LIMIT != 0) && !mem_ready &&
                     (waitCount == CNT_W'(WAIT_LIMIT - 1));

  // A ready that lands on the last allowed wait cycle takes priority over the timeout.
  always_comb begin
    nextState  = state;
    setIllegal = 1'b0;
    setTimeout = 1'b0;
    case (state)
      FETCH: begin
        if (mem_ready) begin
          nextState = DECODE;
        end else if (timeout) begin
          nextState  = TRAP;
          setTimeout = 1'b1;
        end
      end
      DECODE: begin
        case (opcode)
          7'b0110011:             nextState = EXEC_R;
          7'b0010011:             nextState = EXEC_I;
          7'b0000011, 7'b0100011: nextState = MEM_ADDR;
          7'b1100011:             nextState = BRANCH;
          7'b1101111:             nextState = JAL;
          7'b1100111:             nextState = JALR;
          7'b0110111:             nextState = LUI;
          7'b0010111:             nextState = WB_ALU;
          7'b1110011:             nextState = HALT;
          default: begin
            nextState  = TRAP;
            setIllegal = 1'b1;
          end
        endcase
      end
      EXEC_R, EXEC_I, LUI: nextState = WB_ALU;
      WB_ALU, WB_MEM, BRANCH, JAL, JALR: nextState = FETCH;
      MEM_ADDR: nextState = opcode[5] ? MEM_WRITE : MEM_READ;
      MEM_READ, MEM_WRITE: begin
        if (mem_ready) begin
          nextState = (state == MEM_READ) ? WB_MEM : FETCH;
        end else if (timeout) begin
          nextState  = TRAP;
          setTimeout = 1'b1;
        end
      end
      default: nextState = state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH;
      waitCount <= '0;
      halted    <= 1'b0;
      fault     <= 2'b00;
`ifdef INSTR_COUNT_EN
      instret   <= '0;
`endif
    end else begin
      state <= nextState;
      if (nextState != state) begin
        waitCount <= '0;
      end else if (waitState && !mem_ready) begin
        waitCount <= waitCount + 1'b1;
      end
      if (nextState == HALT) begin
        halted <= 1'b1;
      end
      if (setIllegal) begin
        fault <= 2'b01;
      end else if (setTimeout) begin
        fault <= 2'b10;
      end
`ifdef INSTR_COUNT_EN
      if ((state != FETCH) && (nextState == FETCH)) begin
        instret <= instret + 32'd1;
      end
`endif
    end
  end

  // Moore decode, except FETCH gates its writes on mem_ready; reset kills every enable.
  always_comb begin
    MemoryAddressOrigin      = 1'b0;
    ReadMemory               = 1'b0;
    WriteMemory              = 1'b0;
    WriteInstructionRegister = 1'b0;
    WriteCurrentPC           = 1'b0;
    WritePC                  = 1'b0;
    Branch                   = 1'b0;
    PCOrigin                 = 1'b0;
    RegisterInputOrigin      = 2'b00;
    WriteRegister            = 1'b0;
    ALUInputAOrigin          = 2'b00;
    ALUInputBOrigin          = 2'b00;
    ALUOp                    = 2'b00;
    case (state)
      FETCH: begin
        ReadMemory = 1'b1;
        if (mem_ready) begin
          WriteInstructionRegister = 1'b1;
          WriteCurrentPC           = 1'b1;
          ALUInputAOrigin          = 2'b01;
          ALUInputBOrigin          = 2'b01;
          WritePC                  = 1'b1;
        end
      end
      DECODE: ALUInputBOrigin = 2'b10;
      EXEC_R: begin
        ALUInputAOrigin = 2'b10;
        ALUOp           = 2'b10;
      end
      EXEC_I: begin
        ALUInputAOrigin = 2'b10;
        ALUInputBOrigin = 2'b10;
        ALUOp           = 2'b11;
      end
      LUI: begin
        ALUInputAOrigin = 2'b11;
        ALUInputBOrigin = 2'b10;
      end
      WB_ALU: WriteRegister = 1'b1;
      MEM_ADDR: begin
        ALUInputAOrigin = 2'b10;
        ALUInputBOrigin = 2'b10;
      end
      MEM_READ: begin
        MemoryAddressOrigin = 1'b1;
        ReadMemory          = 1'b1;
      end
      WB_MEM: begin
        RegisterInputOrigin = 2'b10;
        WriteRegister       = 1'b1;
      end
      MEM_WRITE: begin
        MemoryAddressOrigin = 1'b1;
        WriteMemory         = 1'b1;
      end
      BRANCH: begin
        ALUInputAOrigin = 2'b10;
        ALUOp           = 2'b01;
        Branch          = 1'b1;
        PCOrigin        = 1'b1;
      end
      JAL: begin
        RegisterInputOrigin = 2'b01;
        WriteRegister       = 1'b1;
        PCOrigin            = 1'b1;
        WritePC             = 1'b1;
      end
      JALR: begin
        ALUInputAOrigin     = 2'b10;
        ALUInputBOrigin     = 2'b10;
        WritePC             = 1'b1;
        RegisterInputOrigin = 2'b01;
        WriteRegister       = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ReadMemory               = 1'b0;
      WriteMemory              = 1'b0;
      WriteInstructionRegister = 1'b0;
      WriteCurrentPC           = 1'b0;
      WritePC                  = 1'b0;
      Branch                   = 1'b0;
      WriteRegister            = 1'b0;
    end
  end

endmodule

// File: tb/tb_multiciclo_sequencer.sv
// Table-driven bench for multiciclo_sequencer: one vector per clock cycle with hand-computed
// state, control word, halted and fault; instret is checked when INSTR_COUNT_EN is defined.
module tb_multiciclo_sequencer;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3;
  localparam logic [3:0] S_LUI   = 4'd4,  S_WB_ALU = 4'd5,  S_MEM_ADDR = 4'd6, S_MEM_READ = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8, S_MEM_WRITE = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11;
  localparam logic [3:0] S_JALR  = 4'd12, S_HALT = 4'd13,   S_TRAP = 4'd14;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS = 7'b1110011, OP_BAD = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        hlt;
    logic [1:0]  flt;
  } vecT;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       MemoryAddressOrigin, ReadMemory, WriteMemory, WriteInstructionRegister;
  logic       WriteCurrentPC, WritePC, Branch, PCOrigin, WriteRegister, halted;
  logic [1:0] RegisterInputOrigin, ALUInputAOrigin, ALUInputBOrigin, ALUOp, fault;
  logic [3:0] state_dbg;
`ifdef INSTR_COUNT_EN
  logic [31:0] instret;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  vecT vecs[$];

  logic [16:0] cZero, cFetchWait, cFetchRdy, cDecode, cExecR, cExecI, cLui, cWbAlu;
  logic [16:0] cMemAddr, cMemRead, cWbMem, cMemWrite, cBranch, cJal, cJalr, enableMask;

  multiciclo_sequencer #(.WAIT_LIMIT(16), .STATE_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .MemoryAddressOrigin(MemoryAddressOrigin), .ReadMemory(ReadMemory),
    .WriteMemory(WriteMemory), .WriteInstructionRegister(WriteInstructionRegister),
    .WriteCurrentPC(WriteCurrentPC), .WritePC(WritePC), .Branch(Branch),
    .PCOrigin(PCOrigin), .RegisterInputOrigin(RegisterInputOrigin),
    .WriteRegister(WriteRegister), .ALUInputAOrigin(ALUInputAOrigin),
    .ALUInputBOrigin(ALUInputBOrigin), .ALUOp(ALUOp), .halted(halted),
    .fault(fault), .state_dbg(state_dbg)
`ifdef INSTR_COUNT_EN
    , .instret(instret)
`endif
  );

  always #5 clock = ~clock;

  // Control word layout: mao rd wr wir wcpc wpc br pco rio[2] wreg a[2] b[2] alu[2]
  function automatic logic [16:0] mk(input logic mao, input logic rd, input logic wr,
                                     input logic wir, input logic wcpc, input logic wpc,
                                     input logic br, input logic pco, input logic [1:0] rio,
                                     input logic wreg, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] alu);
    return {mao, rd, wr, wir, wcpc, wpc, br, pco, rio, wreg, a, b, alu};
  endfunction

  task automatic addV(input logic r, input logic [6:0] op, input logic rdy, input logic [3:0] st,
                      input logic [16:0] c, input logic h, input logic [1:0] f);
    vecT v;
    v.rst = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.hlt = h; v.flt = f;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL vec %0d %s: got 0x%0h, expected 0x%0h", idx, name, got, exp);
    end
  endtask

  task automatic checkOutput(input vecT v, input int idx);
    logic [16:0] got;
    got = mk(MemoryAddressOrigin, ReadMemory, WriteMemory, WriteInstructionRegister,
             WriteCurrentPC, WritePC, Branch, PCOrigin, RegisterInputOrigin, WriteRegister,
             ALUInputAOrigin, ALUInputBOrigin, ALUOp);
    check("state", idx, 32'(state_dbg), 32'(v.st));
    if (v.rst) check("enables", idx, 32'(got & enableMask), 32'(v.ctl & enableMask));
    else       check("controls", idx, 32'(got), 32'(v.ctl));
    check("halted", idx, 32'(halted), 32'(v.hlt));
    check("fault", idx, 32'(fault), 32'(v.flt));
  endtask

  task automatic applyStimulus(input vecT v, input int idx);
    @(negedge clock);
    reset = v.rst;
    opcode = v.op;
    mem_ready = v.rdy;
    #1;
    checkOutput(v, idx);
  endtask

  initial begin
    cZero      = '0;
    cFetchWait = mk(0,1,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00);
    cFetchRdy  = mk(0,1,0,1,1,1,0,0,2'b00,0,2'b01,2'b01,2'b00);
    cDecode    = mk(0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b10,2'b00);
    cExecR     = mk(0,0,0,0,0,0,0,0,2'b00,0,2'b10,2'b00,2'b10);
    cExecI     = mk(0,0,0,0,0,0,0,0,2'b00,0,2'b10,2'b10,2'b11);
    cLui       = mk(0,0,0,0,0,0,0,0,2'b00,0,2'b11,2'b10,2'b00);
    cWbAlu     = mk(0,0,0,0,0,0,0,0,2'b00,1,2'b00,2'b00,2'b00);
    cMemAddr   = mk(0,0,0,0,0,0,0,0,2'b00,0,2'b10,2'b10,2'b00);
    cMemRead   = mk(1,1,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00);
    cWbMem     = mk(0,0,0,0,0,0,0,0,2'b10,1,2'b00,2'b00,2'b00);
    cMemWrite  = mk(1,0,1,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00);
    cBranch    = mk(0,0,0,0,0,0,1,1,2'b00,0,2'b10,2'b00,2'b01);
    cJal       = mk(0,0,0,0,0,1,0,1,2'b01,1,2'b00,2'b00,2'b00);
    cJalr      = mk(0,0,0,0,0,1,0,0,2'b01,1,2'b10,2'b10,2'b00);
    enableMask = mk(0,1,1,1,1,1,1,0,2'b00,1,2'b00,2'b00,2'b00);

    addV(1, OP_R, 1, S_FETCH, cZero, 0, 2'b00);
    addV(0, OP_R, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_R, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_R, 1, S_EXEC_R, cExecR, 0, 2'b00);
    addV(0, OP_R, 1, S_WB_ALU, cWbAlu, 0, 2'b00);
    addV(0, OP_I, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_I, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_I, 1, S_EXEC_I, cExecI, 0, 2'b00);
    addV(0, OP_I, 1, S_WB_ALU, cWbAlu, 0, 2'b00);
    addV(0, OP_LUI, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_LUI, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_LUI, 1, S_LUI, cLui, 0, 2'b00);
    addV(0, OP_LUI, 1, S_WB_ALU, cWbAlu, 0, 2'b00);
    addV(0, OP_AUIPC, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_AUIPC, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_AUIPC, 1, S_WB_ALU, cWbAlu, 0, 2'b00);
    addV(0, OP_BR, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_BR, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_BR, 1, S_BRANCH, cBranch, 0, 2'b00);
    addV(0, OP_JAL, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_JAL, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_JAL, 1, S_JAL, cJal, 0, 2'b00);
    addV(0, OP_JALR, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_JALR, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_JALR, 1, S_JALR, cJalr, 0, 2'b00);
    addV(0, OP_ST, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_ST, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_ST, 1, S_MEM_ADDR, cMemAddr, 0, 2'b00);
    addV(0, OP_ST, 1, S_MEM_WRITE, cMemWrite, 0, 2'b00);
    // Load with a three-cycle memory stall: eight cycles in total.
    addV(0, OP_LD, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_LD, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_LD, 1, S_MEM_ADDR, cMemAddr, 0, 2'b00);
    for (int i = 0; i < 3; i++) addV(0, OP_LD, 0, S_MEM_READ, cMemRead, 0, 2'b00);
    addV(0, OP_LD, 1, S_MEM_READ, cMemRead, 0, 2'b00);
    addV(0, OP_LD, 1, S_WB_MEM, cWbMem, 0, 2'b00);
    addV(0, OP_R, 0, S_FETCH, cFetchWait, 0, 2'b00);
    addV(0, OP_R, 0, S_FETCH, cFetchWait, 0, 2'b00);
    addV(0, OP_R, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_R, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_R, 1, S_EXEC_R, cExecR, 0, 2'b00);
    addV(0, OP_R, 1, S_WB_ALU, cWbAlu, 0, 2'b00);
    // Illegal opcode traps and stays put until reset.
    addV(0, OP_BAD, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_BAD, 1, S_DECODE, cDecode, 0, 2'b00);
    for (int i = 0; i < 10; i++) addV(0, OP_BAD, 1'(i & 1), S_TRAP, cZero, 0, 2'b01);
    addV(1, OP_BAD, 1, S_TRAP, cZero, 0, 2'b01);
    addV(0, OP_SYS, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_SYS, 1, S_DECODE, cDecode, 0, 2'b00);
    for (int i = 0; i < 20; i++) addV(0, OP_SYS, 1'(i & 1), S_HALT, cZero, 1, 2'b00);
    addV(1, OP_SYS, 1, S_HALT, cZero, 1, 2'b00);
    // Reset in the middle of a stalled store drops the write in the same cycle.
    addV(0, OP_ST, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_ST, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_ST, 0, S_MEM_ADDR, cMemAddr, 0, 2'b00);
    addV(0, OP_ST, 0, S_MEM_WRITE, cMemWrite, 0, 2'b00);
    addV(0, OP_ST, 0, S_MEM_WRITE, cMemWrite, 0, 2'b00);
    addV(1, OP_ST, 0, S_MEM_WRITE, cZero, 0, 2'b00);
    addV(0, OP_ST, 0, S_FETCH, cFetchWait, 0, 2'b00);
    // Ready on the last allowed wait cycle beats the timeout.
    addV(0, OP_ST, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_ST, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_ST, 1, S_MEM_ADDR, cMemAddr, 0, 2'b00);
    for (int i = 0; i < 15; i++) addV(0, OP_ST, 0, S_MEM_WRITE, cMemWrite, 0, 2'b00);
    addV(0, OP_ST, 1, S_MEM_WRITE, cMemWrite, 0, 2'b00);
    addV(0, OP_ST, 1, S_FETCH, cFetchRdy, 0, 2'b00);
    addV(0, OP_ST, 1, S_DECODE, cDecode, 0, 2'b00);
    addV(0, OP_ST, 1, S_MEM_ADDR, cMemAddr, 0, 2'b00);
    for (int i = 0; i < 16; i++) addV(0, OP_ST, 0, S_MEM_WRITE, cMemWrite, 0, 2'b00);
    for (int i = 0; i < 3; i++) addV(0, OP_ST, 0, S_TRAP, cZero, 0, 2'b10);
    addV(1, OP_ST, 0, S_TRAP, cZero, 0, 2'b10);
    addV(0, OP_R, 0, S_FETCH, cFetchWait, 0, 2'b00);

    reset = 1'b1;
    opcode = OP_R;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

`ifdef INSTR_COUNT_EN
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("instret_reset", -1, instret, 32'd0);
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = OP_R;
    repeat (4) @(negedge clock);
    #1;
    check("instret_one", -1, instret, 32'd1);
    opcode = OP_SYS;
    repeat (3) @(negedge clock);
    #1;
    check("halted_entry", -1, 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      check("instret_frozen", i, instret, 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
